bf16_fma_arbiter: RTL and testbench
===================================

Name: bf16_fma_arbiter

Overview:
Round-robin arbiter that shares one pipelined bf16_fma between N_REQ requesters.
- Accepts operand triples plus an operation code from each requester over valid/ready.
- Issues at most one operation per cycle to the FMA and tracks the requester ID of each operation through the FMA latency.
- Returns each result and its fpcsr flags to the originating requester.
- A quiesce/drain control lets software stop issue and wait for the FMA pipeline to empty before reconfiguring.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- FMA_LAT, 1, bf16_fma cycles from enable to valid result (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (combinational grant)
- req_a  in  N_REQ*16  operand_a per requester, requester i at [16i+15:16i]
- req_b  in  N_REQ*16  operand_b, same packing
- req_c  in  N_REQ*16  operand_c, same packing
- req_op  in  N_REQ*4  operation code, requester i at [4i+3:4i]
- resp_valid  out  N_REQ  one-hot result pulse, no backpressure
- resp_result  out  16  result bits, shared across requesters
- resp_fpcsr  out  4  fpcsr flags, shared across requesters
- quiesce  in  1  level request: stop issuing and drain
- idle  out  1  high when halted and pipeline empty
- fma_enable  out  1  to bf16_fma enable
- fma_operand_a  out  16  to bf16_fma operand_a
- fma_operand_b  out  16  to bf16_fma operand_b
- fma_operand_c  out  16  to bf16_fma operand_c
- fma_operation  out  4  to bf16_fma operation
- fma_result  in  16  from bf16_fma result
- fma_fpcsr  in  4  from bf16_fma fpcsr
- sticky_fpcsr  out  N_REQ*4  per-requester accumulated flags (see Optional Feature)

Behaviour:
- Reset values:
  - fma_* outputs 0; resp_valid 0; idle 0.
  - State RUN; in-flight count 0; tag pipe cleared.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
- Arbitration:
  - Grant only in state RUN with quiesce=0.
  - Priority order starts at pointer+1 mod N_REQ.
  - req_ready is one-hot on the first requester with req_valid=1, and depends only on req_valid, pointer, state and quiesce.
  - On handshake (valid&ready) of requester g, the pointer becomes g. With no handshake the pointer holds.
- Issue:
  - Handshake at cycle T registers operands and op into fma_*, with fma_enable=1 during T+1.
  - With no handshake, fma_enable=0 and the operand registers hold their values.
  - Throughput is 1 op/cycle.
- Return:
  - The tag pipe (valid + $clog2(N_REQ)-bit id) has depth FMA_LAT+1.
  - In cycle T+1+FMA_LAT: resp_valid[g]=1; resp_result=fma_result and resp_fpcsr=fma_fpcsr, combinational pass-through.
  - Responses retire in issue order.
  - When resp_valid=0, resp_result and resp_fpcsr are don't-care.
- In-flight counter:
  - Width $clog2(FMA_LAT+3).
  - +1 on handshake, -1 on tag-pipe exit, unchanged when both occur.
  - Never exceeds FMA_LAT+1.
- FSM:
  - RUN --quiesce=1--> DRAIN. req_ready is forced 0 combinationally in the same cycle quiesce rises.
  - DRAIN --in-flight==0--> HALTED. DRAIN stays until empty, even if quiesce drops.
  - HALTED: idle=1. HALTED --quiesce=0--> RUN on the next cycle.
  - quiesce asserted with an empty pipe reaches HALTED two cycles later.
- Reset mid-operation: all in-flight ops are dropped with no resp_valid, and the pointer returns to N_REQ-1.
- Requester stability: requesters must hold req_* stable while valid and not ready. The arbiter does not check this.

Optional Feature:
- Macro: BF16_ARB_STICKY_FLAGS_EN.
- Defined:
  - Per-requester 4-bit sticky register, ORed with resp_fpcsr on each resp_valid[i].
  - Cleared to 0 on reset, and on a handshake from requester i whose req_op equals 4'hF. That op is still issued normally.
- Undefined: sticky_fpcsr is tied to 0 and no registers are inferred.

Decomposition:
- Package bf16_arb_pkg:
  - BF16_W=16, OP_W=4, FLAG_W=4
  - arb_state_e {RUN, DRAIN, HALTED}
  - OP_CLR_STICKY=4'hF
- One sub-module: rr_arbiter, a generic N-way round-robin grant with pointer update on accept. It is reused elsewhere in the accelerator.

Test Plan:
- Single request, FMA_LAT=1:
  - Stimulus: req0 a=3F80 b=4000 c=4040 op=7.
  - Required: fma_enable high in cycle T+1; resp_valid=0001 in cycle T+2; resp_result=40A0 (5.0).
- Fairness:
  - Stimulus: all 4 requesters valid continuously for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; one issue per cycle; responses return in the same order with matching ids.
- Quiesce during traffic:
  - Stimulus: raise quiesce with 2 ops in flight.
  - Required: req_ready=0 immediately; both responses still delivered; idle=1 only after the last resp_valid; dropping quiesce resumes grants.
- Reset mid-flight:
  - Stimulus: assert reset with an op in the tag pipe.
  - Required: resp_valid never asserts for that op; after reset, requester 0 wins first.
- Infinity propagation:
  - Stimulus: req2 a=7F80 b=3F80 c=4040.
  - Required: resp_valid[2] with resp_result=7F80; with BF16_ARB_STICKY_FLAGS_EN, sticky_fpcsr[11:8] ORs in the returned flags; an op=F clear request from req2 zeroes them.

Source files
------------

// File: rtl/bf16_fma_arbiter_pkg.sv
// Shared types and constants for the bf16 FMA arbiter.
package bf16_arb_pkg;
   localparam int BF16_W = 16;
   localparam int OP_W   = 4;
   localparam int FLAG_W = 4;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} arb_state_e;

   // Operation code that also clears the issuing requester's sticky flags.
   localparam logic [OP_W-1:0] OP_CLR_STICKY = 4'hF;
endpackage

// File: rtl/bf16_fma_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter. The grant is combinational on i_req;
// the pointer moves to the granted index whenever a grant is given, since
// the grant doubles as the ready/accept of the requester.
module rr_arbiter #(
   parameter  int N    = 4,
   localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    i_req,
   input  logic            i_en,
   output logic [N-1:0]    o_gnt,
   output logic [ID_W-1:0] o_gnt_id,
   output logic            o_gnt_any
);
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_idx;

   // Scan from pointer+1 (mod N) and grant the first active request.
   always_comb begin
      o_gnt     = '0;
      o_gnt_id  = '0;
      o_gnt_any = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = ID_W'((int'(r_ptr) + 1 + k) % N);
         if (i_en && !o_gnt_any && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_gnt_id     = w_idx;
            o_gnt_any    = 1'b1;
         end
      end
   end

   // Pointer starts at N-1 so index 0 has first priority out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_ptr <= ID_W'(N - 1);
      else if (o_gnt_any) r_ptr <= o_gnt_id;
   end
endmodule

// File: rtl/bf16_fma_arbiter.sv
// Round-robin front end sharing one pipelined bf16_fma among N_REQ
// requesters. Requester ids ride a tag pipe alongside the FMA so each result
// is steered back to its issuer. Optional per-requester sticky flags are
// built when BF16_ARB_STICKY_FLAGS_EN is defined.
module bf16_fma_arbiter
   import bf16_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int FMA_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*BF16_W-1:0] req_a,
   input  logic [N_REQ*BF16_W-1:0] req_b,
   input  logic [N_REQ*BF16_W-1:0] req_c,
   input  logic [N_REQ*OP_W-1:0]   req_op,
   output logic [N_REQ-1:0]        resp_valid,
   output logic [BF16_W-1:0]       resp_result,
   output logic [FLAG_W-1:0]       resp_fpcsr,
   input  logic                    quiesce,
   output logic                    idle,
   output logic                    fma_enable,
   output logic [BF16_W-1:0]       fma_operand_a,
   output logic [BF16_W-1:0]       fma_operand_b,
   output logic [BF16_W-1:0]       fma_operand_c,
   output logic [OP_W-1:0]         fma_operation,
   input  logic [BF16_W-1:0]       fma_result,
   input  logic [FLAG_W-1:0]       fma_fpcsr,
   output logic [N_REQ*FLAG_W-1:0] sticky_fpcsr
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(FMA_LAT + 3);

   arb_state_e                  r_state;
   logic                        r_idle;
   logic                        r_fma_en;
   logic [BF16_W-1:0]           r_fma_a, r_fma_b, r_fma_c;
   logic [OP_W-1:0]             r_fma_op;
   logic [FMA_LAT:0]            r_tag_vld;
   logic [FMA_LAT:0][ID_W-1:0]  r_tag_id;
   logic [CNT_W-1:0]            r_inflight;

   logic                        w_en;
   logic [N_REQ-1:0]            w_gnt;
   logic [ID_W-1:0]             w_gid;
   logic                        w_hs;
   logic                        w_exit;

   // Grants are only offered while running and not being asked to quiesce,
   // so ready drops in the same cycle quiesce rises.
   assign w_en = (r_state == RUN) && !quiesce;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .i_req     (req_valid),
      .i_en      (w_en),
      .o_gnt     (w_gnt),
      .o_gnt_id  (w_gid),
      .o_gnt_any (w_hs)
   );

   assign req_ready = w_gnt;
   assign w_exit    = r_tag_vld[FMA_LAT];

   // Capture the winner's operands; the registers hold when nothing issues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fma_en <= 1'b0;
         r_fma_a  <= '0;
         r_fma_b  <= '0;
         r_fma_c  <= '0;
         r_fma_op <= '0;
      end else begin
         r_fma_en <= w_hs;
         if (w_hs) begin
            r_fma_a  <= req_a[int'(w_gid)*BF16_W +: BF16_W];
            r_fma_b  <= req_b[int'(w_gid)*BF16_W +: BF16_W];
            r_fma_c  <= req_c[int'(w_gid)*BF16_W +: BF16_W];
            r_fma_op <= req_op[int'(w_gid)*OP_W +: OP_W];
         end
      end
   end

   assign fma_enable    = r_fma_en;
   assign fma_operand_a = r_fma_a;
   assign fma_operand_b = r_fma_b;
   assign fma_operand_c = r_fma_c;
   assign fma_operation = r_fma_op;

   // Stage 0 lines up with fma_enable; the last stage with the FMA result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[FMA_LAT-1:0], w_hs};
         r_tag_id  <= {r_tag_id[FMA_LAT-1:0], w_gid};
      end
   end

   assign resp_valid  = w_exit ? (N_REQ'(1) << r_tag_id[FMA_LAT]) : '0;
   assign resp_result = fma_result;
   assign resp_fpcsr  = fma_fpcsr;

   // Count operations between handshake and tag-pipe exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= '0;
      end else begin
         case ({w_hs, w_exit})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Quiesce FSM; idle is registered and tracks entry to / exit from HALTED.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_idle  <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (quiesce) r_state <= DRAIN;
            end
            DRAIN: begin
               if (r_inflight == '0) begin
                  r_state <= HALTED;
                  r_idle  <= 1'b1;
               end
            end
            HALTED: begin
               if (!quiesce) begin
                  r_state <= RUN;
                  r_idle  <= 1'b0;
               end
            end
            default: begin
               r_state <= RUN;
               r_idle  <= 1'b0;
            end
         endcase
      end
   end

   assign idle = r_idle;

`ifdef BF16_ARB_STICKY_FLAGS_EN
   logic [N_REQ-1:0][FLAG_W-1:0] r_sticky;

   // Accumulate returned flags; a clear-op handshake wins over a same-cycle
   // result for that requester.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sticky <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i] && (req_op[i*OP_W +: OP_W] == OP_CLR_STICKY))
               r_sticky[i] <= '0;
            else if (resp_valid[i])
               r_sticky[i] <= r_sticky[i] | fma_fpcsr;
         end
      end
   end

   assign sticky_fpcsr = r_sticky;
`else
   assign sticky_fpcsr = '0;
`endif
endmodule

// File: tb/tb_bf16_fma_arbiter.sv
// Directed bench for bf16_fma_arbiter with a stub FMA. The stub knows the
// exact bf16 answers for the vectors used here and otherwise returns an
// XOR tag so results can be matched to their issuer; flags echo the op.
module tb_bf16_fma_arbiter;
   localparam int N_REQ   = 4;
   localparam int FMA_LAT = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ*16-1:0]  req_a, req_b, req_c;
   logic [N_REQ*4-1:0]   req_op;
   logic [N_REQ-1:0]     resp_valid;
   logic [15:0]          resp_result;
   logic [3:0]           resp_fpcsr;
   logic                 quiesce;
   logic                 idle;
   logic                 fma_enable;
   logic [15:0]          fma_operand_a, fma_operand_b, fma_operand_c;
   logic [3:0]           fma_operation;
   logic [15:0]          fma_result;
   logic [3:0]           fma_fpcsr;
   logic [N_REQ*4-1:0]   sticky_fpcsr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bf16_fma_arbiter #(.N_REQ(N_REQ), .FMA_LAT(FMA_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_op(req_op),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_fpcsr(resp_fpcsr),
      .quiesce(quiesce), .idle(idle), .fma_enable(fma_enable),
      .fma_operand_a(fma_operand_a), .fma_operand_b(fma_operand_b),
      .fma_operand_c(fma_operand_c), .fma_operation(fma_operation),
      .fma_result(fma_result), .fma_fpcsr(fma_fpcsr), .sticky_fpcsr(sticky_fpcsr)
   );

   function automatic logic [15:0] stub_res(logic [15:0] a, logic [15:0] b,
                                            logic [15:0] c, logic [3:0] op);
      if (a == 16'h3F80 && b == 16'h4000 && c == 16'h4040) return 16'h40A0;
      if (a == 16'h7F80) return 16'h7F80;
      return a ^ b ^ c ^ {12'h000, op};
   endfunction

   // Stub FMA pipeline, FMA_LAT stages deep.
   logic [FMA_LAT-1:0][15:0] st_res;
   logic [FMA_LAT-1:0][3:0]  st_flg;
   always @(posedge clk) begin
      st_res[0] <= stub_res(fma_operand_a, fma_operand_b, fma_operand_c, fma_operation);
      st_flg[0] <= fma_operation;
      for (int i = 1; i < FMA_LAT; i++) begin
         st_res[i] <= st_res[i-1];
         st_flg[i] <= st_flg[i-1];
      end
   end
   assign fma_result = st_res[FMA_LAT-1];
   assign fma_fpcsr  = st_flg[FMA_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [3:0] op);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
      req_c[i*16 +: 16] = c;
      req_op[i*4 +: 4]  = op;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      quiesce   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (fma_enable !== 1'b0 || resp_valid !== 4'b0 || idle !== 1'b0 ||
          sticky_fpcsr !== 16'h0 || fma_operand_a !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs en=%b rv=%b idle=%b sticky=%h a=%h (want 0)",
                  fma_enable, resp_valid, idle, sticky_fpcsr, fma_operand_a);
      end
      tick();
      reset     = 1'b0;
      req_valid = 4'hF;
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_priority ready=%b want 0001", req_ready);
      end
      req_valid = 4'h0;
   endtask

   task automatic test_single();
      set_req(0, 16'h3F80, 16'h4000, 16'h4040, 4'h7);
      req_valid = 4'b0001;
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready ready=%b want 0001", req_ready);
      end
      tick();
      req_valid = 4'b0;
      #3;
      checks++;
      if (fma_enable !== 1'b1 || fma_operand_a !== 16'h3F80 || fma_operand_b !== 16'h4000 ||
          fma_operand_c !== 16'h4040 || fma_operation !== 4'h7) begin
         errors++;
         $display("FAIL single_issue en=%b a=%h b=%h c=%h op=%h want 1 3F80 4000 4040 7",
                  fma_enable, fma_operand_a, fma_operand_b, fma_operand_c, fma_operation);
      end
      checks++;
      if (resp_valid !== 4'b0) begin
         errors++;
         $display("FAIL single_early_resp rv=%b want 0000", resp_valid);
      end
      tick();
      #3;
      checks++;
      if (resp_valid !== 4'b0001 || resp_result !== 16'h40A0 || fma_enable !== 1'b0 ||
          fma_operand_a !== 16'h3F80) begin
         errors++;
         $display("FAIL single_resp rv=%b res=%h en=%b a=%h want 0001 40A0 0 3F80",
                  resp_valid, resp_result, fma_enable, fma_operand_a);
      end
      tick();
      #3;
      checks++;
      if (resp_valid !== 4'b0) begin
         errors++;
         $display("FAIL single_resp_pulse rv=%b want 0000", resp_valid);
      end
   endtask

   task automatic test_fairness();
      logic [3:0]  exp_oh;
      logic [15:0] exp_r;
      int          g;
      do_reset();
      for (int i = 0; i < N_REQ; i++)
         set_req(i, 16'h1000 + 16'(i), 16'h0200, 16'h0030, 4'(i));
      for (int k = 0; k < 11; k++) begin
         req_valid = (k < 8) ? 4'hF : 4'h0;
         #3;
         if (k < 8) begin
            exp_oh = 4'(1 << (k % 4));
            checks++;
            if (req_ready !== exp_oh) begin
               errors++;
               $display("FAIL fair_grant k=%0d ready=%b want %b", k, req_ready, exp_oh);
            end
         end
         if (k >= 1 && k <= 8) begin
            g = (k - 1) % 4;
            checks++;
            if (fma_enable !== 1'b1 || fma_operand_a !== 16'h1000 + 16'(g)) begin
               errors++;
               $display("FAIL fair_issue k=%0d en=%b a=%h want 1 %h", k, fma_enable,
                        fma_operand_a, 16'h1000 + 16'(g));
            end
         end
         if (k >= 2 && k <= 9) begin
            g      = (k - 2) % 4;
            exp_oh = 4'(1 << g);
            exp_r  = (16'h1000 + 16'(g)) ^ 16'h0200 ^ 16'h0030 ^ 16'(g);
            checks++;
            if (resp_valid !== exp_oh || resp_result !== exp_r || resp_fpcsr !== 4'(g)) begin
               errors++;
               $display("FAIL fair_resp k=%0d rv=%b res=%h fl=%h want %b %h %h", k,
                        resp_valid, resp_result, resp_fpcsr, exp_oh, exp_r, 4'(g));
            end
         end
         if (k == 10) begin
            checks++;
            if (resp_valid !== 4'b0 || fma_enable !== 1'b0) begin
               errors++;
               $display("FAIL fair_tail rv=%b en=%b want 0000 0", resp_valid, fma_enable);
            end
         end
         tick();
      end
   endtask

   task automatic test_quiesce();
      set_req(0, 16'h2000, 16'h0001, 16'h0002, 4'h1);
      set_req(1, 16'h3000, 16'h0001, 16'h0002, 4'h2);
      req_valid = 4'b0011;
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL q_grant0 ready=%b want 0001", req_ready);
      end
      tick();
      #3;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL q_grant1 ready=%b want 0010", req_ready);
      end
      tick();
      quiesce = 1'b1;
      #3;
      checks++;
      if (req_ready !== 4'b0 || resp_valid !== 4'b0001 || idle !== 1'b0 ||
          resp_result !== (16'h2000 ^ 16'h0003 ^ 16'h0001)) begin
         errors++;
         $display("FAIL q_c2 ready=%b rv=%b idle=%b res=%h want 0000 0001 0 2002",
                  req_ready, resp_valid, idle, resp_result);
      end
      tick();
      #3;
      checks++;
      if (req_ready !== 4'b0 || resp_valid !== 4'b0010 || idle !== 1'b0 ||
          resp_result !== (16'h3000 ^ 16'h0003 ^ 16'h0002)) begin
         errors++;
         $display("FAIL q_c3 ready=%b rv=%b idle=%b res=%h want 0000 0010 0 3001",
                  req_ready, resp_valid, idle, resp_result);
      end
      tick();
      #3;
      checks++;
      if (idle !== 1'b0 || resp_valid !== 4'b0 || req_ready !== 4'b0) begin
         errors++;
         $display("FAIL q_c4 idle=%b rv=%b ready=%b want 0 0000 0000", idle, resp_valid, req_ready);
      end
      tick();
      #3;
      checks++;
      if (idle !== 1'b1 || req_ready !== 4'b0) begin
         errors++;
         $display("FAIL q_halted idle=%b ready=%b want 1 0000", idle, req_ready);
      end
      tick();
      quiesce = 1'b0;
      #3;
      checks++;
      if (idle !== 1'b1 || req_ready !== 4'b0) begin
         errors++;
         $display("FAIL q_release idle=%b ready=%b want 1 0000", idle, req_ready);
      end
      tick();
      #3;
      checks++;
      if (idle !== 1'b0 || req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL q_resume idle=%b ready=%b want 0 0001", idle, req_ready);
      end
      tick();
      req_valid = 4'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_midflight();
      int seen;
      set_req(2, 16'h4400, 16'h0101, 16'h0202, 4'h3);
      req_valid = 4'b0100;
      #3;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL mid_grant ready=%b want 0100", req_ready);
      end
      tick();
      req_valid = 4'b0;
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (fma_enable !== 1'b0) begin
         errors++;
         $display("FAIL mid_enable_clear en=%b want 0", fma_enable);
      end
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) reset = 1'b0;
         #3;
         if (resp_valid !== 4'b0) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_no_resp cycles_with_resp=%0d want 0", seen);
      end
      req_valid = 4'hF;
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL mid_ptr_reset ready=%b want 0001", req_ready);
      end
      req_valid = 4'b0;
   endtask

   task automatic test_infinity();
      logic [15:0] exp_s1, exp_s2;
`ifdef BF16_ARB_STICKY_FLAGS_EN
      exp_s1 = 16'h0700;
      exp_s2 = 16'h0F00;
`else
      exp_s1 = 16'h0000;
      exp_s2 = 16'h0000;
`endif
      do_reset();
      set_req(2, 16'h7F80, 16'h3F80, 16'h4040, 4'h7);
      req_valid = 4'b0100;
      #3;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL inf_grant ready=%b want 0100", req_ready);
      end
      tick();
      req_valid = 4'b0;
      tick();
      #3;
      checks++;
      if (resp_valid !== 4'b0100 || resp_result !== 16'h7F80 || resp_fpcsr !== 4'h7) begin
         errors++;
         $display("FAIL inf_resp rv=%b res=%h fl=%h want 0100 7F80 7",
                  resp_valid, resp_result, resp_fpcsr);
      end
      tick();
      #3;
      checks++;
      if (sticky_fpcsr !== exp_s1) begin
         errors++;
         $display("FAIL inf_sticky sticky=%h want %h", sticky_fpcsr, exp_s1);
      end
      set_req(2, 16'h0000, 16'h0000, 16'h0000, 4'hF);
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0;
      #3;
      checks++;
      if (sticky_fpcsr !== 16'h0000) begin
         errors++;
         $display("FAIL sticky_clear sticky=%h want 0000", sticky_fpcsr);
      end
      tick();
      #3;
      checks++;
      if (resp_valid !== 4'b0100 || resp_fpcsr !== 4'hF) begin
         errors++;
         $display("FAIL clr_resp rv=%b fl=%h want 0100 F", resp_valid, resp_fpcsr);
      end
      tick();
      #3;
      checks++;
      if (sticky_fpcsr !== exp_s2) begin
         errors++;
         $display("FAIL sticky_reaccum sticky=%h want %h", sticky_fpcsr, exp_s2);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_c     = '0;
      req_op    = '0;
      quiesce   = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_quiesce();
      test_reset_midflight();
      test_infinity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
